// File: rtl/rvv_pkg.sv
// rvv_pkg: RISC-V vector architectural types shared by the Spatz lanes.
package rvv_pkg;

    typedef enum logic [1:0] {
        EW_8  = 2'd0,
        EW_16 = 2'd1,
        EW_32 = 2'd2,
        EW_64 = 2'd3
    } vew_e;

endpackage

// File: rtl/spatz_pkg.sv
// spatz_pkg: lane operation encoding and the lane sequencer FSM states.
package spatz_pkg;

    typedef enum logic [5:0] {
        VADD, VSUB, VRSUB, VAND, VOR, VXOR,
        VMIN, VMINU, VMAX, VMAXU,
        VMUL, VMULH, VMULHU,
        VDIV, VDIVU, VREM, VREMU,
        VADC, VSBC, VMADC, VMSBC,
        VSLL, VSRL, VSRA
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // Only the add/sub-with-carry family consumes the per-element carry bit.
    function automatic logic has_carry(op_e op);
        return op == VADC || op == VSBC || op == VMADC || op == VMSBC;
    endfunction

endpackage

// File: rtl/spatz_lane_sequencer.sv
// spatz_lane_sequencer: steps one vector request element by element through a
// SIMD lane and returns the results through a skid-free writeback register.
module spatz_lane_sequencer
    import spatz_pkg::*;
    import rvv_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned MaxVl = 64,
    localparam int unsigned VlW  = $clog2(MaxVl + 1),
    localparam int unsigned IdxW = $clog2(MaxVl)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  op_e              req_op_i,
    input  logic [VlW-1:0]   req_vl_i,
    input  vew_e             req_sew_i,
    input  logic             req_signed_i,
    input  logic             opd_valid_i,
    output logic             opd_ready_o,
    input  logic [Width-1:0] opd_s1_i,
    input  logic [Width-1:0] opd_s2_i,
    input  logic [Width-1:0] opd_d_i,
    input  logic             opd_carry_i,
    output op_e              operation_o,
    output logic             operation_valid_o,
    output logic [Width-1:0] op_s1_o,
    output logic [Width-1:0] op_s2_o,
    output logic [Width-1:0] op_d_o,
    output logic             is_signed_o,
    output logic             carry_o,
    output vew_e             sew_o,
    input  logic [Width-1:0] result_i,
    input  logic             result_valid_i,
    output logic             result_ready_o,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [Width-1:0] wb_data_o,
    output logic [IdxW-1:0]  wb_idx_o,
    output logic             wb_last_o,
    output logic             busy_o
);

    seq_state_e       state_q, state_d;
    op_e              op_q, op_d;
    vew_e             sew_q, sew_d;
    logic             signed_q, signed_d;
    logic [VlW-1:0]   vl_q, vl_d;
    logic [IdxW-1:0]  cnt_q, cnt_d;
    logic             wb_valid_q, wb_valid_d;
    logic [Width-1:0] wb_data_q, wb_data_d;
    logic [IdxW-1:0]  wb_idx_q, wb_idx_d;
    logic             wb_last_q, wb_last_d;
    logic             complete, is_last;

    assign is_last           = VlW'(cnt_q) == vl_q - VlW'(1);
    assign req_ready_o       = state_q == IDLE;
    assign operation_o       = op_q;
    assign sew_o             = sew_q;
    assign is_signed_o       = signed_q;
    assign op_s1_o           = opd_s1_i;
    assign op_s2_o           = opd_s2_i;
    assign op_d_o            = opd_d_i;
    assign carry_o           = has_carry(op_q) && opd_carry_i;
    assign operation_valid_o = state_q == ISSUE && opd_valid_i;
    // Hold the lane while the writeback register is full and not draining.
    assign result_ready_o    = state_q == ISSUE && (!wb_valid_q || wb_ready_i);
    assign complete          = result_valid_i && result_ready_o;
    assign opd_ready_o       = complete;
    assign wb_valid_o        = wb_valid_q;
    assign wb_data_o         = wb_data_q;
    assign wb_idx_o          = wb_idx_q;
    assign wb_last_o         = wb_last_q;
    assign busy_o            = state_q != IDLE || wb_valid_q;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        sew_d      = sew_q;
        signed_d   = signed_q;
        vl_d       = vl_q;
        cnt_d      = complete ? cnt_q + IdxW'(1) : cnt_q;
        wb_valid_d = complete || (wb_valid_q && !wb_ready_i);
        wb_data_d  = complete ? result_i : wb_data_q;
        wb_idx_d   = complete ? cnt_q : wb_idx_q;
        wb_last_d  = complete ? is_last : wb_last_q;
        unique case (state_q)
            IDLE: if (req_valid_i) begin
                op_d     = req_op_i;
                sew_d    = req_sew_i;
                signed_d = req_signed_i;
                vl_d     = req_vl_i;
                cnt_d    = '0;
                state_d  = req_vl_i != '0 ? ISSUE : IDLE;
            end
            ISSUE: if (complete && is_last) state_d = DRAIN;
            DRAIN: if (wb_valid_q && wb_ready_i && wb_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            op_q       <= op_e'('0);
            sew_q      <= vew_e'('0);
            signed_q   <= 1'b0;
            vl_q       <= '0;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_idx_q   <= '0;
            wb_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            sew_q      <= sew_d;
            signed_q   <= signed_d;
            vl_q       <= vl_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_idx_q   <= wb_idx_d;
            wb_last_q  <= wb_last_d;
        end
    end

endmodule
